// File: rtl/mat_bram_init.sv
// Single-clock BRAM of ROWS*COLS words that fills itself with an arithmetic sequence
// (BASE + STEP*k) and then serves external reads and writes.
module mat_bram_init #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned ROWS      = 3,
  parameter int unsigned COLS      = 5,
  parameter int unsigned BASE      = 15,
  parameter int unsigned STEP      = 10,
  parameter bit          AUTO_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       Depth    = ROWS * COLS;
  localparam int unsigned       IdxW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [ADDR_W:0]   DepthA   = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0]   LastAddr = (ADDR_W + 1)'(Depth - 1);
  localparam logic [DATA_W-1:0] BaseW    = DATA_W'(BASE);
  localparam logic [DATA_W-1:0] StepW    = DATA_W'(STEP);

  if ((Depth == 0) || (((Depth - 1) >> ADDR_W) != 0)) begin : g_depth_chk
    $error("mat_bram_init: ROWS*COLS must be in 1..2**ADDR_W");
  end

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W:0]   fill_addr_q;
  logic [DATA_W-1:0] fill_val_q;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q, rd_err_q;
  logic [DATA_W-1:0] mem_q [Depth];

  logic              wr_ok, rd_ok;
  logic              mem_we;
  logic [IdxW-1:0]   mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign wr_ok = wr_en && (state_q == StDone) && ({1'b0, wr_addr} < DepthA);
  assign rd_ok = rd_en && (state_q == StDone) && ({1'b0, rd_addr} < DepthA);

  // Single write port shared by the fill engine and external writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state_q == StFill) begin
      mem_we    = 1'b1;
      mem_waddr = fill_addr_q[IdxW-1:0];
      mem_wdata = fill_val_q;
    end else if (wr_ok) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr[IdxW-1:0];
      mem_wdata = wr_data;
    end
  end

  // Storage is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      fill_addr_q <= '0;
      fill_val_q  <= BaseW;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      rd_err_q   <= rd_en && !rd_ok;
      if (rd_ok) begin
        rd_data_q <= mem_q[rd_addr[IdxW-1:0]];
      end

      unique case (state_q)
        StIdle: begin
          if (start || AUTO_INIT) begin
            state_q     <= StFill;
            fill_addr_q <= '0;
            fill_val_q  <= BaseW;
            busy_q      <= 1'b1;
          end
        end
        StFill: begin
          fill_addr_q <= fill_addr_q + 1'b1;
          fill_val_q  <= fill_val_q + StepW;
          if (fill_addr_q == LastAddr) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (start) begin
            state_q     <= StFill;
            fill_addr_q <= '0;
            fill_val_q  <= BaseW;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
